conv_result_streamer: RTL and testbench

- Reads the 2-D result image that conv2d has written into result memory.
- Streams it out in raster order over a valid/ready interface.
- Sits between the result memory read port and the downstream consumer (host link / next layer).
- Counterpart of conv2d's write side: conv2d fills result memory; this block drains it once conv2d reports ready.

---
 rtl/conv_pkg.sv | 19 +
 rtl/result_fifo2.sv | 51 +++++
 rtl/conv_result_streamer.sv | 134 +++++++++++++
 tb/tb_conv_result_streamer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the conv2d result path.
// The optional RESULT_CLAMP_EN macro is consumed by conv_result_streamer.
package conv_pkg;

    localparam int AddressBitWidth   = 17;
    localparam int DataBitWidth      = 12;
    localparam int ImageSizeBitWidth = 8;

    // Result image geometry, shared with conv2d's write side.
    localparam int NoOfRows    = 5;
    localparam int NoOfColumns = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry FIFO holding {data, row_last, frame_last} words between the
// result memory read port and the valid/ready output.
module result_fifo2 #(
    parameter int Width = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [Width-1:0] head
);

    logic [Width-1:0] entry_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                entry_reg[gi] <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                entry_reg[gi] <= push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count      <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = entry_reg[rd_ptr_reg];

endmodule

// File: rtl/conv_result_streamer.sv
// Drains the conv2d result image from result memory in raster order onto a
// valid/ready stream. Define RESULT_CLAMP_EN to clamp negative words to zero.
module conv_result_streamer #(
    parameter int AddressBitWidth   = conv_pkg::AddressBitWidth,
    parameter int DataBitWidth      = conv_pkg::DataBitWidth,
    parameter int ImageSizeBitWidth = conv_pkg::ImageSizeBitWidth,
    parameter int NoOfColumns       = conv_pkg::NoOfColumns,
    parameter int NoOfRows          = conv_pkg::NoOfRows
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [AddressBitWidth-1:0] ReadAddress,
    output logic                       ReadEnable,
    input  logic [DataBitWidth-1:0]    d_in,
    output logic [DataBitWidth-1:0]    m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_row_last,
    output logic                       m_frame_last,
    output logic                       busy,
    output logic                       done
);
    import conv_pkg::*;

    localparam int Total  = NoOfRows * NoOfColumns;
    localparam int EntryW = DataBitWidth + 2;

    state_t                       state_reg;
    logic [ImageSizeBitWidth-1:0] row_reg;
    logic [ImageSizeBitWidth-1:0] col_reg;
    logic                         inflight_reg;
    logic                         pend_row_last_reg;
    logic                         pend_frame_last_reg;

    logic [1:0]              fifo_count;
    logic [EntryW-1:0]       head;
    logic [EntryW-1:0]       push_entry;
    logic [DataBitWidth-1:0] push_data;
    logic                    pop;
    logic [2:0]              occupancy;
    logic                    issue_row_last;
    logic                    issue_frame_last;

    assign pop       = m_valid & m_ready;
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_reg};

    // ReadAddress doubles as the issued-word counter. The pop term lets a
    // word be issued into the slot freed this cycle, sustaining 1 word/cycle.
    assign ReadEnable = (state_reg == STREAM)
                     && (ReadAddress < AddressBitWidth'(Total))
                     && (occupancy < (3'd2 + {2'b00, pop}));

    assign issue_row_last   = (col_reg == ImageSizeBitWidth'(NoOfColumns - 1));
    assign issue_frame_last = issue_row_last
                           && (row_reg == ImageSizeBitWidth'(NoOfRows - 1));

    always_comb begin
        push_data = d_in;
`ifdef RESULT_CLAMP_EN
        if (d_in[DataBitWidth-1]) begin
            push_data = '0;
        end
`endif
    end

    assign push_entry = {push_data, pend_row_last_reg, pend_frame_last_reg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg           <= IDLE;
            ReadAddress         <= '0;
            row_reg             <= '0;
            col_reg             <= '0;
            inflight_reg        <= 1'b0;
            pend_row_last_reg   <= 1'b0;
            pend_frame_last_reg <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else begin
            inflight_reg <= ReadEnable;
            if (ReadEnable) begin
                pend_row_last_reg   <= issue_row_last;
                pend_frame_last_reg <= issue_frame_last;
                ReadAddress         <= ReadAddress + 1'b1;
                if (issue_row_last) begin
                    col_reg <= '0;
                    if (!issue_frame_last) begin
                        row_reg <= row_reg + 1'b1;
                    end
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end

            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg   <= STREAM;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        ReadAddress <= '0;
                        row_reg     <= '0;
                        col_reg     <= '0;
                    end
                end
                STREAM: begin
                    if (pop && m_frame_last) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    result_fifo2 #(
        .Width(EntryW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_reg),
        .push_data(push_entry),
        .pop      (pop),
        .count    (fifo_count),
        .head     (head)
    );

    assign m_valid = (fifo_count != 2'd0);
    assign {m_data, m_row_last, m_frame_last} = head;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Self-checking bench for conv_result_streamer: frame scenarios from a table,
// expected pixels derived from memory contents and raster-order arithmetic.
module tb_conv_result_streamer;
    import conv_pkg::*;

    localparam int AW    = AddressBitWidth;
    localparam int DW    = DataBitWidth;
    localparam int Cols  = NoOfColumns;
    localparam int Total = NoOfRows * NoOfColumns;

    typedef struct {
        int ready_mode;      // 0 always ready, 1 pattern 1,0,0,1, 2 random
        int mem_mode;        // 0 word=address, 1 random, 2 clamp words then random
        int restart_at;      // pulse start while this many transfers done (-1 none)
        int abort_at;        // drop rst after this many transfers (-1 none)
        int exp_first_valid;
        int exp_transfers;
    } scen_t;

    typedef struct {
        logic [DW-1:0] word;
        logic [DW-1:0] exp;
    } clamp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] ReadAddress;
    logic          ReadEnable;
    logic [DW-1:0] d_in = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_row_last;
    logic          m_frame_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [Total];
    clamp_t        clamp_tab [4];
    int            tests  = 0;
    int            failed = 0;

    always #5 clk = ~clk;

    conv_result_streamer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ReadAddress (ReadAddress),
        .ReadEnable  (ReadEnable),
        .d_in        (d_in),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_row_last  (m_row_last),
        .m_frame_last(m_frame_last),
        .busy        (busy),
        .done        (done)
    );

    // Result memory: one-cycle registered read.
    always @(posedge clk) begin
        if (ReadEnable && (int'(ReadAddress) < Total)) begin
            d_in <= mem[int'(ReadAddress)];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_pixel(input logic [DW-1:0] w);
`ifdef RESULT_CLAMP_EN
        return w[DW-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, ReadAddress, 0);
        check({tag, "_re"}, ReadEnable, 0);
        check({tag, "_data"}, m_data, 0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_row_last"}, m_row_last, 0);
        check({tag, "_frame_last"}, m_frame_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic run_frame(input int idx, input scen_t s);
        logic [DW+1:0] exp_q [$];
        logic [DW+1:0] held;
        logic          pattern [4];
        logic          stalled;
        logic          aborted;
        int            cyc, xfers, issued, first_valid, last_xfer_cyc;

        pattern = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < Total; i++) begin
            case (s.mem_mode)
                0:       mem[i] = DW'(i);
                2:       mem[i] = (i < 4) ? clamp_tab[i].word : DW'($urandom);
                default: mem[i] = DW'($urandom);
            endcase
        end
        for (int i = 0; i < Total; i++) begin
            logic [DW-1:0] px;
            px = (s.mem_mode == 2 && i < 4) ? clamp_tab[i].exp : ref_pixel(mem[i]);
            exp_q.push_back({px, (i % Cols) == Cols - 1, i == Total - 1});
        end

        cyc = 0; xfers = 0; issued = 0; first_valid = -1; last_xfer_cyc = -1;
        stalled = 1'b0; aborted = 1'b0; held = '0;

        @(negedge clk);
        start   = 1'b1;
        m_ready = 1'b1;
        while (xfers < Total && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (xfers == s.abort_at) begin
                rst = 1'b0;
                #1;
                check_all_zero("abort");
                aborted = 1'b1;
                break;
            end
            start = (xfers == s.restart_at);
            case (s.ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = pattern[(cyc - 1) % 4];
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (cyc == 1) begin
                check("re_latency", ReadEnable, 1);
                check("busy_on_start", busy, 1);
                check("done_on_start", done, 0);
            end
            if (first_valid < 0 && m_valid) first_valid = cyc;
            if (stalled) begin
                check("stall_valid", m_valid, 1);
                check("stall_head", 32'({m_data, m_row_last, m_frame_last}), 32'(held));
            end
            if (ReadEnable) begin
                check("rd_addr", ReadAddress, issued);
                check("rd_space", 32'((issued - xfers - int'(m_valid && m_ready)) < 2), 1);
                issued++;
            end
            if (m_valid && m_ready) begin
                check("xfer_data", 32'(m_data), 32'(exp_q[xfers][DW+1:2]));
                check("xfer_row_last", m_row_last, exp_q[xfers][1]);
                check("xfer_frame_last", m_frame_last, exp_q[xfers][0]);
                xfers++;
                last_xfer_cyc = cyc;
            end
            stalled = m_valid && !m_ready;
            held    = {m_data, m_row_last, m_frame_last};
        end
        start = 1'b0;

        check("transfers", xfers, s.exp_transfers);
        check("first_valid", first_valid, s.exp_first_valid);
        if (aborted) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            check_all_zero("post_abort");
        end else begin
            check("issued", issued, Total);
            if (s.ready_mode == 0) begin
                check("throughput", last_xfer_cyc, s.exp_first_valid + Total - 1);
            end
            @(negedge clk);
            m_ready = 1'b0;
            #1;
            check("done_after", done, 1);
            check("busy_after", busy, 0);
            check("valid_after", m_valid, 0);
            check("re_after", ReadEnable, 0);
        end
        $display("[TB] frame %0d: mode %0d, %0d transfers in %0d cycles", idx, s.ready_mode, xfers, cyc);
    endtask

    initial begin
        scen_t scen [9];

        clamp_tab[0].word = 12'hFFF;
        clamp_tab[1].word = 12'h800;
        clamp_tab[2].word = 12'h7FF;
        clamp_tab[3].word = 12'h001;
`ifdef RESULT_CLAMP_EN
        clamp_tab[0].exp = 12'h000;
        clamp_tab[1].exp = 12'h000;
`else
        clamp_tab[0].exp = 12'hFFF;
        clamp_tab[1].exp = 12'h800;
`endif
        clamp_tab[2].exp = 12'h7FF;
        clamp_tab[3].exp = 12'h001;

        scen[0] = '{0, 0, -1, -1, 3, Total};
        scen[1] = '{1, 0, -1, -1, 3, Total};
        scen[2] = '{0, 0, 10, -1, 3, Total};
        scen[3] = '{0, 0, -1, -1, 3, Total};
        scen[4] = '{0, 0, -1,  7, 3, 7};
        scen[5] = '{0, 0, -1, -1, 3, Total};
        scen[6] = '{2, 1, -1, -1, 3, Total};
        scen[7] = '{0, 2, -1, -1, 3, Total};
        scen[8] = '{2, 2, 12, -1, 3, Total};

        rst     = 1'b1;
        start   = 1'b0;
        m_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_frame(i, scen[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
